// File: rtl/frame_accum_pkg.sv
// Shared types and constants for the frame accumulator.
// DEPTH and width checks are evaluated where the parameters live (top level).
package frame_accum_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/frame_accum_buf.sv
// DEPTH x ACC_WIDTH element store: one synchronous write port, one combinational read port.
// Storage is deliberately not reset; every run rewrites all entries during LOAD.
module frame_accum_buf #(
  parameter int DEPTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [IDX_W-1:0]     i_waddr,
  input  logic [ACC_WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]     i_raddr,
  output logic [ACC_WIDTH-1:0] o_rdata
);

  logic [ACC_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/frame_accum_fifo.sv
// Frame accumulator: combines each element position across frames (saturating sum or max),
// then streams the DEPTH results out under valid/ready backpressure.
//
// state | meaning
// LOAD  | first frame of a run, buffer overwritten with samples
// ACCUM | later frames, buffer combined with samples
// DRAIN | results streamed out, input stalled
module frame_accum_fifo
  import frame_accum_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int ACC_WIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 ovf
);

  localparam int IDX_W = $clog2(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_chk_depth
    $error("frame_accum_fifo: DEPTH must be a power of two >= 2");
  end
  if (ACC_WIDTH < WIDTH) begin : g_chk_width
    $error("frame_accum_fifo: ACC_WIDTH must be >= WIDTH");
  end

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_mode;
  logic [CNT_W-1:0]     r_frame_cnt;
  logic                 r_ovf;

  logic                 w_in_fire;
  logic                 w_last_idx;
  logic [ACC_WIDTH-1:0] w_rd;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_sat;
  logic [ACC_WIDTH-1:0] w_wdata;

  assign in_ready   = (r_state != DRAIN);
  assign out_valid  = (r_state == DRAIN);
  assign w_in_fire  = in_valid & in_ready;
  assign w_last_idx = (r_idx == IDX_W'(DEPTH - 1));
  assign out_data   = out_valid ? w_rd : '0;
  assign out_last   = out_valid & w_last_idx;
  assign frame_cnt  = r_frame_cnt;
  assign ovf        = r_ovf;

  // One extra bit so the carry out of the sum flags the clamp.
  assign w_ext = ACC_WIDTH'(in_data);
  assign w_sum = {1'b0, w_rd} + {1'b0, w_ext};
  assign w_sat = w_sum[ACC_WIDTH];

  always_comb begin
    w_wdata = w_ext;
    if (r_state == ACCUM) begin
      if (r_mode == MODE_MAX) w_wdata = (w_rd > w_ext) ? w_rd : w_ext;
      else                    w_wdata = w_sat ? '1 : w_sum[ACC_WIDTH-1:0];
    end
  end

  frame_accum_buf #(
    .DEPTH     (DEPTH),
    .ACC_WIDTH (ACC_WIDTH),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_in_fire),
    .i_waddr (r_idx),
    .i_wdata (w_wdata),
    .i_raddr (r_idx),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= LOAD;
      r_idx       <= '0;
      r_mode      <= MODE_SUM;
      r_frame_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        LOAD: if (in_valid) begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == '0) begin
            r_mode      <= mode;
            r_ovf       <= 1'b0;
            r_frame_cnt <= CNT_W'(1);
          end
          if (w_last_idx) r_state <= in_last ? DRAIN : ACCUM;
        end
        ACCUM: if (in_valid) begin
          r_idx <= r_idx + 1'b1;
          if (r_mode == MODE_SUM && w_sat) r_ovf <= 1'b1;
          if (w_last_idx) begin
            if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (in_last) r_state <= DRAIN;
          end
        end
        DRAIN: if (out_ready) begin
          r_idx <= r_idx + 1'b1;
          if (w_last_idx) r_state <= LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_accum_fifo.sv
// Randomized bench for frame_accum_fifo against a per-run array model of the
// combine rules (overwrite, saturating sum, running max).
module tb_frame_accum_fifo;

  localparam int WIDTH     = 12;
  localparam int ACC_WIDTH = 16;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = 8;
  localparam int AMAX      = (1 << ACC_WIDTH) - 1;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data = '0;
  logic                 in_last = 1'b0;
  logic                 mode = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_last;
  logic [CNT_W-1:0]     frame_cnt;
  logic                 ovf;

  int n_vec = 0;
  int n_err = 0;
  int exp_q [DEPTH];
  int max_tab [3][DEPTH] = '{'{5, 0, 9, 1, 4, 4, 0, 2},
                             '{2, 7, 9, 3, 0, 6, 1, 2},
                             '{8, 1, 3, 3, 2, 5, 0, 7}};

  always #5 clk = ~clk;

  frame_accum_fifo #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_cnt(frame_cnt), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int exp_fc, input bit exp_ovf);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_out_data", out_data, 0);
    chk("idle_out_last", out_last, 0);
    chk("idle_frame_cnt", frame_cnt, exp_fc);
    chk("idle_ovf", ovf, exp_ovf);
  endtask

  function automatic int samp(input int kind, input int base, input int f, input int i);
    case (kind)
      0:       return int'($urandom_range(0, (1 << WIDTH) - 1));
      1:       return base;
      2:       return base + i;
      default: return max_tab[f % 3][i];
    endcase
  endfunction

  // Drives one beat from a negedge; returns at the negedge after the accepting edge.
  task automatic beat(input int d, input bit lst, input bit md);
    bit ok;
    ok = 0;
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b1;
    in_data   = WIDTH'(d);
    in_last   = lst;
    mode      = md;
    out_ready = 1'(($urandom));
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin
        ok = 1;
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("in_ready_timeout", 0, 1);
  endtask

  function automatic bit oready(input int ork, input int cyc);
    case (ork)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return 1'(($urandom));
    endcase
  endfunction

  task automatic drain(input int ork, input int exp_fc, input bit exp_ovf);
    int k;
    int cyc;
    bit fire;
    k = 0;
    cyc = 0;
    while (k < DEPTH && cyc < 200) begin
      in_valid  = 1'b1;
      in_data   = WIDTH'($urandom);
      in_last   = 1'(($urandom));
      out_ready = oready(ork, cyc);
      chk("drain_out_valid", out_valid, 1);
      chk("drain_in_ready", in_ready, 0);
      chk("drain_out_data", out_data, exp_q[k]);
      chk("drain_out_last", out_last, (k == DEPTH - 1));
      chk("drain_frame_cnt", frame_cnt, exp_fc);
      chk("drain_ovf", ovf, exp_ovf);
      fire = out_ready & out_valid;
      @(posedge clk);
      @(negedge clk);
      if (fire) k++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (k < DEPTH) chk("drain_timeout", k, DEPTH);
    chk_idle(exp_fc, exp_ovf);
  endtask

  task automatic run(input int nf, input bit md, input int kind, input int base, input int ork);
    int acc [DEPTH];
    bit ov;
    int x;
    ov = 0;
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        x = samp(kind, base, f, i);
        if (f == 0) acc[i] = x;
        else if (md == 1'b0) begin
          acc[i] = acc[i] + x;
          if (acc[i] > AMAX) begin
            acc[i] = AMAX;
            ov = 1;
          end
        end else if (x > acc[i]) acc[i] = x;
        beat(x,
             (i == DEPTH - 1) ? (f == nf - 1) : 1'(($urandom)),
             (f == 0 && i == 0) ? md : 1'(($urandom)));
      end
    end
    exp_q = acc;
    drain(ork, (nf > CMAX) ? CMAX : nf, ov);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_idle(0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk_idle(0, 0);

    run(3, 1'b0, 2, 1, 0);
    run(1, 1'b0, 2, 100, 0);
    run(17, 1'b0, 1, 4095, 2);
    run(1, 1'b0, 1, 1, 0);
    run(3, 1'b1, 3, 0, 0);
    run(4, 1'b0, 0, 0, 1);
    run(2, 1'b1, 0, 0, 1);
    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(1, 5)), 1'(($urandom)), 0, 0, 2);
    run(260, 1'b0, 0, 0, 0);

    // Abandon a run in ACCUM at frame 2, element 4.
    for (int i = 0; i < DEPTH; i++) beat(int'($urandom_range(0, 4095)), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) beat(int'($urandom_range(0, 4095)), 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk_idle(0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(2, 1'b0, 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
